// File: rtl/wb_register_file_pkg.sv
// rtl/wb_register_file_pkg.sv - shared widths, zero-register address and WB control bundle
package wb_register_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Same bit order as the 2-bit WB control field: bit1 RegWrite, bit0 MemToReg
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_read_port.sv
// rtl/wb_read_port.sv - one GPR read port with $zero forcing and optional write-through (WB_REGFILE_BYPASS_EN)
module wb_read_port
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              commit,
  input  logic [ADDR_W-1:0] commit_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

`ifndef WB_REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{commit, commit_addr, wb_data};
`endif

  always_comb begin
    data = regs[addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (addr == commit_addr)) data = wb_data;
`endif
    // $zero wins over both the array and the bypass path
    if (addr == ADDR_W'(REG_ZERO)) data = '0;
  end

endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - MEM/WB write-back mux, 32x32 GPR array, written flags and commit counter
// Optional same-cycle write-through on the read ports when WB_REGFILE_BYPASS_EN is defined.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 RegWrite_i,
  input  logic                 MemToReg_i,
  input  logic [DATA_W-1:0]    Mem_data_i,
  input  logic [DATA_W-1:0]    ALU_data_i,
  input  logic [ADDR_W-1:0]    RegWriteAddr_i,
  input  logic [ADDR_W-1:0]    RSaddr_i,
  input  logic [ADDR_W-1:0]    RTaddr_i,
  output logic [DATA_W-1:0]    RSdata_o,
  output logic [DATA_W-1:0]    RTdata_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic [2**ADDR_W-1:0] written_o,
  output logic [CNT_W-1:0]     wb_count_o
);

  wb_ctrl_t          ctrl;
  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [DATA_W-1:0] regs [2**ADDR_W];

  assign ctrl      = '{reg_write: RegWrite_i, mem_to_reg: MemToReg_i};
  assign wb_data   = ctrl.mem_to_reg ? Mem_data_i : ALU_data_i;
  assign wb_data_o = wb_data;
  assign commit    = ctrl.reg_write && (RegWriteAddr_i != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      written_o  <= '0;
      wb_count_o <= '0;
    end else if (commit) begin
      regs[RegWriteAddr_i]      <= wb_data;
      written_o[RegWriteAddr_i] <= 1'b1;
      if (wb_count_o != {CNT_W{1'b1}}) wb_count_o <= wb_count_o + 1'b1;
    end
  end

  wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
    .addr        (RSaddr_i),
    .regs        (regs),
    .commit      (commit),
    .commit_addr (RegWriteAddr_i),
    .wb_data     (wb_data),
    .data        (RSdata_o)
  );

  wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
    .addr        (RTaddr_i),
    .regs        (regs),
    .commit      (commit),
    .commit_addr (RegWriteAddr_i),
    .wb_data     (wb_data),
    .data        (RTdata_o)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - directed self-checking bench for wb_register_file (both bypass builds)
module tb_wb_register_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i;
  logic        MemToReg_i;
  logic [31:0] Mem_data_i;
  logic [31:0] ALU_data_i;
  logic [4:0]  RegWriteAddr_i;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [31:0] RSdata_o, RTdata_o, wb_data_o, written_o, wb_count_o;
  logic [31:0] s_rs, s_rt, s_wb, s_written;
  logic [3:0]  s_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  wb_register_file dut (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .Mem_data_i(Mem_data_i), .ALU_data_i(ALU_data_i), .RegWriteAddr_i(RegWriteAddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
    .wb_data_o(wb_data_o), .written_o(written_o), .wb_count_o(wb_count_o)
  );

  wb_register_file #(.CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .Mem_data_i(Mem_data_i), .ALU_data_i(ALU_data_i), .RegWriteAddr_i(RegWriteAddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(s_rs), .RTdata_o(s_rt),
    .wb_data_o(s_wb), .written_o(s_written), .wb_count_o(s_count)
  );

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wa);
    RegWrite_i = we; MemToReg_i = m2r; Mem_data_i = mem; ALU_data_i = alu; RegWriteAddr_i = wa;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    RSaddr_i = 5'd5; RTaddr_i = 5'd31;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'h0 || RTdata_o !== 32'h0) $display("FAIL reset_reads rs=%h rt=%h want 0", RSdata_o, RTdata_o);
    else pass_cnt++;
    total_cnt++;
    if (written_o !== 32'h0 || wb_count_o !== 32'h0) $display("FAIL reset_state written=%h count=%0d want 0/0", written_o, wb_count_o);
    else pass_cnt++;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_commit_alu;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0000_0999, 32'h0000_1234, 5'd8);
    RSaddr_i = 5'd8;
    #1;
    total_cnt++;
    if (wb_data_o !== 32'h0000_1234) $display("FAIL alu_wb_data got %h want 00001234", wb_data_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    total_cnt++;
    if (RSdata_o !== 32'h0000_1234) $display("FAIL alu_rs8 got %h want 00001234", RSdata_o);
    else pass_cnt++;
    total_cnt++;
    if (written_o !== 32'h0000_0100 || wb_count_o !== 32'd1) $display("FAIL alu_flags written=%h count=%0d want 00000100/1", written_o, wb_count_o);
    else pass_cnt++;
    @(negedge clk_i);
    RegWrite_i = 1'b0;
  endtask

  task automatic test_commit_mem;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31);
    RTaddr_i = 5'd31;
    #1;
    total_cnt++;
    if (wb_data_o !== 32'hDEAD_BEEF) $display("FAIL mem_wb_data got %h want deadbeef", wb_data_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    #1;
    total_cnt++;
    if (RTdata_o !== 32'hDEAD_BEEF) $display("FAIL mem_rt31 got %h want deadbeef", RTdata_o);
    else pass_cnt++;
    total_cnt++;
    if (written_o !== 32'h8000_0100 || wb_count_o !== 32'd2) $display("FAIL mem_flags written=%h count=%0d want 80000100/2", written_o, wb_count_o);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    RSaddr_i = 5'd0; RTaddr_i = 5'd0;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'h0 || RTdata_o !== 32'h0) $display("FAIL zero_no_bypass rs=%h rt=%h want 0", RSdata_o, RTdata_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    total_cnt++;
    if (RSdata_o !== 32'h0) $display("FAIL zero_rs0 got %h want 0", RSdata_o);
    else pass_cnt++;
    total_cnt++;
    if (written_o !== 32'h8000_0100 || wb_count_o !== 32'd2) $display("FAIL zero_flags written=%h count=%0d want 80000100/2", written_o, wb_count_o);
    else pass_cnt++;
    // wb_data_o follows the mux even without RegWrite, and nothing commits
    @(negedge clk_i);
    drive(1'b0, 1'b1, 32'h0000_0ABC, 32'h0000_0DEF, 5'd4);
    RSaddr_i = 5'd4;
    #1;
    total_cnt++;
    if (wb_data_o !== 32'h0000_0ABC) $display("FAIL idle_wb_data got %h want 00000abc", wb_data_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    total_cnt++;
    if (RSdata_o !== 32'h0 || wb_count_o !== 32'd2) $display("FAIL idle_no_commit rs4=%h count=%0d want 0/2", RSdata_o, wb_count_o);
    else pass_cnt++;
  endtask

  task automatic test_bypass;
    logic [31:0] exp_same;
`ifdef WB_REGFILE_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'h11;
`endif
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd9);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd9);
    RSaddr_i = 5'd9; RTaddr_i = 5'd9;
    #1;
    total_cnt++;
    if (RSdata_o !== exp_same || RTdata_o !== exp_same) $display("FAIL same_cycle_r9 rs=%h rt=%h want %h", RSdata_o, RTdata_o, exp_same);
    else pass_cnt++;
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'h55 || RTdata_o !== 32'h55) $display("FAIL next_cycle_r9 rs=%h rt=%h want 00000055", RSdata_o, RTdata_o);
    else pass_cnt++;
    total_cnt++;
    if (wb_count_o !== 32'd4) $display("FAIL bypass_count got %0d want 4", wb_count_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd10);
    RSaddr_i = 5'd10; RTaddr_i = 5'd8;
    #1 rst_i = 1'b0;
    #1;
    total_cnt++;
    if (RTdata_o !== 32'h0 || written_o !== 32'h0 || wb_count_o !== 32'h0) $display("FAIL async_reset rt8=%h written=%h count=%0d want 0/0/0", RTdata_o, written_o, wb_count_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    total_cnt++;
    if (RSdata_o !== 32'h0 || wb_count_o !== 32'h0) $display("FAIL write_lost rs10=%h count=%0d want 0/0", RSdata_o, wb_count_o);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 32'h0, 32'(i), 5'(i));
      @(posedge clk_i); #1;
      if (i == 14) begin
        total_cnt++;
        if (s_count !== 4'hE) $display("FAIL sat_at14 got %h want e", s_count);
        else pass_cnt++;
      end
    end
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    RSaddr_i = 5'd20; RTaddr_i = 5'd15;
    #1;
    total_cnt++;
    if (s_count !== 4'hF) $display("FAIL sat_hold got %h want f", s_count);
    else pass_cnt++;
    total_cnt++;
    if (wb_count_o !== 32'd20) $display("FAIL count20 got %0d want 20", wb_count_o);
    else pass_cnt++;
    total_cnt++;
    if (s_written !== 32'h001F_FFFE) $display("FAIL sat_written got %h want 001ffffe", s_written);
    else pass_cnt++;
    total_cnt++;
    if (s_rs !== 32'd20 || s_rt !== 32'd15 || RSdata_o !== 32'd20) $display("FAIL sat_reads rs=%h rt=%h main_rs=%h want 14/0f/14", s_rs, s_rt, RSdata_o);
    else pass_cnt++;
    total_cnt++;
    if (s_wb !== 32'd20) $display("FAIL sat_wb_data got %h want 00000014", s_wb);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_commit_alu();
    test_commit_mem();
    test_zero_reg();
    test_bypass();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
